// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO with occupancy counter, status flags, registered
// read data and one-cycle-latency write/read acknowledge and error handshakes.
module fifo_ctrl_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic [$clog2(DEPTH):0]     data_count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       wr_ack,
    output logic                       wr_err,
    output logic                       rd_ack,
    output logic                       rd_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};

    typedef enum logic [2:0] {
        ST_INIT   = 3'b000,
        ST_NO_OP  = 3'b001,
        ST_WRITE  = 3'b010,
        ST_WR_ERR = 3'b011,
        ST_READ   = 3'b100,
        ST_RD_ERR = 3'b101,
        ST_RDWR   = 3'b110,
        ST_ILL    = 3'b111
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           w_count_nxt;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_full;
    logic                    r_empty;
    logic                    r_af;
    logic                    r_ae;
    logic                    r_wr_ack;
    logic                    r_wr_err;
    logic                    r_rd_ack;
    logic                    r_rd_err;
    logic                    w_live;
    logic                    w_wr_ok;
    logic                    w_rd_ok;

    // The illegal encoding ignores requests for one edge and recovers to NO_OP.
    assign w_live  = (r_state != ST_ILL);
    assign w_wr_ok = w_live & wr_en & (r_count != C_DEPTH);
    assign w_rd_ok = w_live & rd_en & (r_count != C_ZERO);

    // Next occupancy from accepted requests.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_ok && w_rd_ok) begin
            w_count_nxt = r_count - CW'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Next FSM state; a rejected half of a simultaneous request does not change the state class.
    always_comb begin
        w_state_nxt = ST_NO_OP;
        if (!w_live) begin
            w_state_nxt = ST_NO_OP;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b11:   w_state_nxt = ST_RDWR;
                2'b10:   w_state_nxt = ST_WRITE;
                2'b01:   w_state_nxt = ST_READ;
                default: begin
                    if (wr_en) begin
                        w_state_nxt = ST_WR_ERR;
                    end else if (rd_en) begin
                        w_state_nxt = ST_RD_ERR;
                    end else begin
                        w_state_nxt = ST_NO_OP;
                    end
                end
            endcase
        end
    end

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= din;
        end
    end

    // State, pointers, counter, registered data and handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_INIT;
            r_wptr   <= {PW{1'b0}};
            r_rptr   <= {PW{1'b0}};
            r_count  <= C_ZERO;
            r_dout   <= {DATA_WIDTH{1'b0}};
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ack <= w_wr_ok;
            r_rd_ack <= w_rd_ok;
            r_wr_err <= w_live & wr_en & ~w_wr_ok;
            r_rd_err <= w_live & rd_en & ~w_rd_ok;
            if (w_wr_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + PW'(1);
                r_dout <= r_mem[r_rptr];
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == C_DEPTH);
            r_empty  <= (w_count_nxt == C_ZERO);
            r_af     <= (w_count_nxt >= C_AF);
            r_ae     <= (w_count_nxt <= C_AE);
        end
    end

    assign dout         = r_dout;
    assign data_count   = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign wr_ack       = r_wr_ack;
    assign wr_err       = r_wr_err;
    assign rd_ack       = r_rd_ack;
    assign rd_err       = r_rd_err;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Scoreboard bench for fifo_ctrl_param: a queue-based FIFO model predicts every
// cycle's outputs, a monitor compares them one time unit after each rising edge.
module tb_fifo_ctrl_param;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic [CW-1:0] data_count;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [DW-1:0] dout;
        int            cnt;
        logic          full, empty, af, ae, wa, we, ra, re;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;

    fifo_ctrl_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .din(din),
        .dout(dout), .data_count(data_count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: FIFO as a queue, predicting outputs after each edge.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                exp_q.delete();
                m_dout = '0;
            end else begin
                automatic bit   w_ok = wr_en && (mq.size() < DEPTH);
                automatic bit   r_ok = rd_en && (mq.size() > 0);
                automatic exp_t e;
                if (r_ok) m_dout = mq.pop_front();
                if (w_ok) mq.push_back(din);
                e.dout  = m_dout;
                e.cnt   = mq.size();
                e.full  = (mq.size() == DEPTH);
                e.empty = (mq.size() == 0);
                e.af    = (mq.size() >= AF);
                e.ae    = (mq.size() <= AE);
                e.wa    = w_ok;
                e.we    = wr_en && !w_ok;
                e.ra    = r_ok;
                e.re    = rd_en && !r_ok;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compare DUT against the oldest prediction, away from the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                automatic exp_t e = exp_q.pop_front();
                chk("dout",         dout,                 e.dout);
                chk("data_count",   DW'(data_count),      DW'(e.cnt));
                chk("full",         DW'(full),            DW'(e.full));
                chk("empty",        DW'(empty),           DW'(e.empty));
                chk("almost_full",  DW'(almost_full),     DW'(e.af));
                chk("almost_empty", DW'(almost_empty),    DW'(e.ae));
                chk("wr_ack",       DW'(wr_ack),          DW'(e.wa));
                chk("wr_err",       DW'(wr_err),          DW'(e.we));
                chk("rd_ack",       DW'(rd_ack),          DW'(e.ra));
                chk("rd_err",       DW'(rd_err),          DW'(e.re));
            end
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dout"},   dout,              '0);
        chk({tag, "_count"},  DW'(data_count),   '0);
        chk({tag, "_full"},   DW'(full),         '0);
        chk({tag, "_empty"},  DW'(empty),        DW'(1));
        chk({tag, "_af"},     DW'(almost_full),  '0);
        chk({tag, "_ae"},     DW'(almost_empty), DW'(1));
        chk({tag, "_wr_ack"}, DW'(wr_ack),       '0);
        chk({tag, "_wr_err"}, DW'(wr_err),       '0);
        chk({tag, "_rd_ack"}, DW'(rd_ack),       '0);
        chk({tag, "_rd_err"}, DW'(rd_err),       '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b1;
        #2 check_reset_vals("rst_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) idle();
        @(posedge clk); #2;
        check_reset_vals("rst_idle");

        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, DW'(i));
        cyc(1'b1, 1'b0, 32'h0000_00FF);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        idle();

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, $urandom);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, '0);

        cyc(1'b1, 1'b1, 32'hA5A5_0001);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, $urandom);
        cyc(1'b1, 1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, '0);

        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, $urandom);
        cyc(1'b1, 1'b0, $urandom);
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_mid");
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b0;
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        idle();

        for (int ph = 0; ph < 4; ph++) begin
            automatic int wb = (ph % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 100; i++) begin
                cyc(($urandom_range(0, 99) < wb), ($urandom_range(0, 99) >= wb),
                    $urandom);
            end
        end
        idle();
        idle();
        @(posedge clk); #3;

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
